// File: rtl/frmclk_pll_ctrl.sv
// Reset/lock sequencer for the frame-clock PLL, clocked by the free-running refclk.
// Holds the PLL in reset, qualifies lock over a stability window and publishes frmclk_ready_o.
module frmclk_pll_ctrl #(
  parameter int RST_HOLD_CYCLES     = 120,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 120000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       manual_reset_i,
  output logic       pll_rst_o,
  output logic       frmclk_ready_o,
  output logic [2:0] state_o,
  output logic [1:0] retry_cnt_o,
  output logic [7:0] relock_cnt_o,
  output logic       timeout_err_o
);

  localparam logic [2:0] RESET_HOLD = 3'd0;
  localparam logic [2:0] WAIT_LOCK  = 3'd1;
  localparam logic [2:0] STABILIZE  = 3'd2;
  localparam logic [2:0] READY      = 3'd3;
  localparam logic [2:0] FAILED     = 3'd4;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

  logic [1:0]       lk_sync;
  logic             lk;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_d;
  logic [7:0]       relock_d;
  logic             terr_d;
  logic [2:0]       retry_inc;

  // pll_locked_i is asynchronous to refclk; only the second stage is ever used
  assign lk        = lk_sync[1];
  assign state_o   = state_q;
  assign retry_inc = {1'b0, retry_cnt_o} + 3'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    retry_d  = retry_cnt_o;
    relock_d = relock_cnt_o;
    terr_d   = timeout_err_o;
    if (manual_reset_i) begin
      state_d = RESET_HOLD;
      cnt_d   = '0;
      retry_d = '0;
      terr_d  = 1'b0;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        WAIT_LOCK: begin
          // a lock seen on the timeout cycle takes precedence over the timeout
          if (lk) begin
            state_d = STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_inc[1:0];
            cnt_d   = '0;
            if (retry_inc == RETRY_LIMIT) begin
              state_d = FAILED;
              terr_d  = 1'b1;
            end else begin
              state_d = RESET_HOLD;
            end
          end
        end
        STABILIZE: begin
          if (!lk) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = READY;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        READY: begin
          cnt_d = '0;
          if (!lk) begin
            state_d = RESET_HOLD;
            if (relock_cnt_o != 8'hFF) relock_d = relock_cnt_o + 8'd1;
          end
        end
        FAILED: begin
          cnt_d  = '0;
          terr_d = 1'b1;
        end
        default: begin
          state_d = RESET_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // outputs are decoded from the next state so they change on the same edge as state_o
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      lk_sync        <= '0;
      state_q        <= RESET_HOLD;
      cnt_q          <= '0;
      pll_rst_o      <= 1'b1;
      frmclk_ready_o <= 1'b0;
      retry_cnt_o    <= '0;
      relock_cnt_o   <= '0;
      timeout_err_o  <= 1'b0;
    end else begin
      lk_sync        <= {lk_sync[0], pll_locked_i};
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pll_rst_o      <= (state_d == RESET_HOLD) || (state_d == FAILED);
      frmclk_ready_o <= (state_d == READY);
      retry_cnt_o    <= retry_d;
      relock_cnt_o   <= relock_d;
      timeout_err_o  <= terr_d;
    end
  end

endmodule

// File: tb/tb_frmclk_pll_ctrl.sv
// Self-checking bench for frmclk_pll_ctrl with short hold/stable/timeout windows.
// Vector table plus hand-written sequences for lock glitches, relock saturation and races.
module tb_frmclk_pll_ctrl;

  logic       refclk = 1'b0;
  logic       rst_n, pll_locked_i, manual_reset_i;
  logic       pll_rst_o, frmclk_ready_o, timeout_err_o;
  logic [2:0] state_o;
  logic [1:0] retry_cnt_o;
  logic [7:0] relock_cnt_o;

  frmclk_pll_ctrl #(
    .RST_HOLD_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES(2), .CNT_W(17)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked_i(pll_locked_i),
    .manual_reset_i(manual_reset_i), .pll_rst_o(pll_rst_o),
    .frmclk_ready_o(frmclk_ready_o), .state_o(state_o), .retry_cnt_o(retry_cnt_o),
    .relock_cnt_o(relock_cnt_o), .timeout_err_o(timeout_err_o)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic       rst_n, locked, manual;
    int         cycles;
    logic [2:0] st;
    logic       prst, rdy;
    logic [1:0] retry;
    logic [7:0] relock;
    logic       terr;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [15:0] exp;
    int          idx;
  } sb_t;

  vec_t vecs[12];
  sb_t  sb_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  function automatic logic [15:0] outs();
    return {state_o, pll_rst_o, frmclk_ready_o, retry_cnt_o, relock_cnt_o, timeout_err_o};
  endfunction

  function automatic logic [15:0] pack(input vec_t v);
    return {v.st, v.prst, v.rdy, v.retry, v.relock, v.terr};
  endfunction

  // scoreboard: entries tagged with the edge they belong to, compared on the following negedge
  always @(negedge refclk) begin : sb_mon
    sb_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      chk($sformatf("vec%0d@%0d", e.idx, e.cyc), outs(), e.exp);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rst_n          = vecs[i].rst_n;
      pll_locked_i   = vecs[i].locked;
      manual_reset_i = vecs[i].manual;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        sb_q.push_back('{cyc + 1, pack(vecs[i]), i});
        step(1);
      end
    end
    for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(negedge refclk);
    #1;
    if (sb_q.size() > 0) begin
      chk("sb_drain", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic count_rst_high(output int n);
    n = 0;
    while (pll_rst_o && n < 200) begin
      n++;
      step(1);
    end
  endtask

  task automatic count_state(input logic [2:0] s, output int n);
    n = 0;
    while (state_o == s && n < 200) begin
      n++;
      step(1);
    end
  endtask

  task automatic wait_ready(output int n, output int first_stab);
    n = 0;
    first_stab = -1;
    while (!frmclk_ready_o && n < 200) begin
      step(1);
      n++;
      if (first_stab < 0 && state_o == 3'd2) first_stab = n;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int n, fs;
    rst_n = 1'b0; pll_locked_i = 1'b0; manual_reset_i = 1'b0;
    //          rst lck man cyc   st  prst rdy retry relock terr
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 3,    3'd0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1,    3'd0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 3,    3'd0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1,    3'd1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 31,   3'd1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1,    3'd0, 1'b1, 1'b0, 2'd1, 8'd0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 3,    3'd0, 1'b1, 1'b0, 2'd1, 8'd0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1,    3'd1, 1'b0, 1'b0, 2'd1, 8'd0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 31,   3'd1, 1'b0, 1'b0, 2'd1, 8'd0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1,    3'd4, 1'b1, 1'b0, 2'd2, 8'd0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1000, 3'd4, 1'b1, 1'b0, 2'd2, 8'd0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1,    3'd0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0};

    // reset values
    run_vecs(0, 0);

    // clean lock: reset pulse counted from the last reset-asserted cycle
    rst_n = 1'b1;
    count_rst_high(n);
    chk("t1_rst_width", n, 4);
    chk("t1_wait_state", state_o, 1);
    step(10);
    pll_locked_i = 1'b1;
    step(1);
    wait_ready(n, fs);
    chk("t1_stab_entry", fs, 2);
    chk("t1_ready_latency", n, 10);
    chk("t1_state_ready", state_o, 3);
    chk("t1_retry", retry_cnt_o, 0);

    // one-cycle lock glitch in STABILIZE
    pll_locked_i = 1'b0; manual_reset_i = 1'b1;
    step(1);
    manual_reset_i = 1'b0;
    count_rst_high(n);
    chk("t2_rst_width", n, 4);
    pll_locked_i = 1'b1;
    step(3);
    chk("t2_stab", state_o, 2);
    step(3);
    pll_locked_i = 1'b0;
    step(1);
    pll_locked_i = 1'b1;
    step(1);
    chk("t2_still_stab", state_o, 2);
    step(1);
    chk("t2_back_wait", state_o, 1);
    chk("t2_rdy_low", frmclk_ready_o, 0);
    chk("t2_relock", relock_cnt_o, 0);
    wait_ready(n, fs);
    chk("t2_ready_latency", n, 9);
    chk("t2_relock_after", relock_cnt_o, 0);

    // timeouts into FAILED, stuck for 1000 cycles
    run_vecs(1, 10);

    // recovery from FAILED by manual reset
    run_vecs(11, 11);
    manual_reset_i = 1'b0; pll_locked_i = 1'b1;
    wait_ready(n, fs);
    chk("t4_ready_latency", n, 13);
    chk("t4_retry", retry_cnt_o, 0);
    chk("t4_terr", timeout_err_o, 0);

    // repeated loss of lock in READY
    for (int i = 0; i < 257; i++) begin
      pll_locked_i = 1'b0;
      step(2);
      chk($sformatf("t5_rdy_hold[%0d]", i), frmclk_ready_o, 1);
      step(1);
      chk($sformatf("t5_rdy_drop[%0d]", i), {frmclk_ready_o, state_o}, 0);
      pll_locked_i = 1'b1;
      count_rst_high(n);
      chk($sformatf("t5_rst_width[%0d]", i), n, 4);
      wait_ready(n, fs);
      chk($sformatf("t5_relocked[%0d]", i), frmclk_ready_o, 1);
      if (i == 0)   chk("t5_relock_first", relock_cnt_o, 1);
      if (i == 254) chk("t5_relock_255", relock_cnt_o, 255);
    end
    chk("t5_relock_sat", relock_cnt_o, 255);

    // lk rises exactly on the WAIT_LOCK timeout cycle of the second attempt
    pll_locked_i = 1'b0; manual_reset_i = 1'b1;
    step(1);
    manual_reset_i = 1'b0;
    count_rst_high(n);
    chk("t6_rst_width", n, 4);
    count_state(3'd1, n);
    chk("t6_wait_len", n, 32);
    chk("t6_retry1", retry_cnt_o, 1);
    count_rst_high(n);
    chk("t6_rst_width2", n, 4);
    step(29);
    pll_locked_i = 1'b1;
    step(2);
    chk("t6_pre_timeout", state_o, 1);
    step(1);
    chk("t6_lock_wins", state_o, 2);
    chk("t6_retry_kept", retry_cnt_o, 1);
    wait_ready(n, fs);
    chk("t6_ready", frmclk_ready_o, 1);
    chk("t6_retry_cleared", retry_cnt_o, 0);

    // manual reset held for several cycles keeps restarting RESET_HOLD
    manual_reset_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("t7_hold[%0d]", i), {state_o, pll_rst_o, frmclk_ready_o}, 3'b010);
    end
    manual_reset_i = 1'b0;
    count_rst_high(n);
    chk("t7_rst_width", n, 4);
    wait_ready(n, fs);
    chk("t7_ready", frmclk_ready_o, 1);
    chk("t7_relock_kept", relock_cnt_o, 255);

    // synchronous reset while READY
    rst_n = 1'b0;
    step(1);
    chk("t8_reset_outs", outs(), 16'b000_1_0_00_00000000_0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
